// File: rtl/branch_predictor_gs2.sv
// branch_predictor_gs2: 2-way LRU BTB, gshare PHT and a return-address stack enabled by BP_RAS_EN.
// rst is asynchronous active-low; flush is a synchronous clear that takes priority over training.
module branch_predictor_gs2 #(
   parameter int BTB_SETS    = 8,
   parameter int PHT_ENTRIES = 64,
   parameter int HIST_LEN    = 6,
   parameter int CNT_BITS    = 2,
   parameter int RAS_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IF_DONE,
   input  logic        MEM_DONE,
   input  logic        flush,
   input  logic [31:0] IF_PC,
   output logic        IF_pTaken,
   output logic [31:0] IF_pTarget,
   input  logic [2:0]  EX_bType,
   input  logic        EX_rTaken,
   input  logic [31:0] EX_PC,
   input  logic [31:0] EX_bTarget,
   input  logic [31:0] EX_linkAddr
);
   localparam int SB = $clog2(BTB_SETS);
   localparam int PB = $clog2(PHT_ENTRIES);
   localparam int TW = 30 - SB;
   localparam logic [CNT_BITS-1:0] WT   = {1'b1, {(CNT_BITS-1){1'b0}}};
   localparam logic [CNT_BITS-1:0] WNT  = WT - CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CMAX = '1;
   localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

   logic [1:0]          valid  [BTB_SETS];
   logic [TW-1:0]       tag    [BTB_SETS][2];
   logic [31:0]         target [BTB_SETS][2];
   logic [1:0]          kind   [BTB_SETS][2];
   logic [BTB_SETS-1:0] lru;
   logic [CNT_BITS-1:0] pht    [PHT_ENTRIES];
   logic [HIST_LEN-1:0] ghr;

   logic [SB-1:0]       if_set, ex_set;
   logic [TW-1:0]       if_tag, ex_tag;
   logic [PB-1:0]       if_idx, ex_idx;
   logic [1:0]          if_hit, ex_hit, ex_kind, hk;
   logic                if_way, ex_way, upd, is_cond, ras_ok, unused_ok;
   logic [CNT_BITS-1:0] pc_cnt, cnt_nxt;
   logic [31:0]         ras_top;

   assign if_set  = IF_PC[SB+1:2];
   assign if_tag  = IF_PC[31:SB+2];
   assign if_idx  = IF_PC[PB+1:2] ^ PB'(ghr);
   assign ex_set  = EX_PC[SB+1:2];
   assign ex_tag  = EX_PC[31:SB+2];
   assign ex_idx  = EX_PC[PB+1:2] ^ PB'(ghr);
   assign if_hit  = {valid[if_set][1] && tag[if_set][1] == if_tag, valid[if_set][0] && tag[if_set][0] == if_tag};
   assign ex_hit  = {valid[ex_set][1] && tag[ex_set][1] == ex_tag, valid[ex_set][0] && tag[ex_set][0] == ex_tag};
   assign if_way  = !if_hit[0];
   // Hit way first, then the first invalid way, then the LRU way.
   assign ex_way  = |ex_hit ? !ex_hit[0] : !valid[ex_set][0] ? 1'b0 : !valid[ex_set][1] ? 1'b1 : lru[ex_set];
   assign ex_kind = EX_bType == 3'b011 ? 2'd2 : EX_bType == 3'b100 ? 2'd3 : EX_bType == 3'b010 ? 2'd0 : 2'd1;
   assign upd     = IF_DONE && MEM_DONE && !flush && EX_bType != 3'b000;
   assign is_cond = EX_bType == 3'b010;
   assign pc_cnt  = pht[ex_idx];
   assign cnt_nxt = !(|ex_hit) ? (EX_rTaken ? WT : WNT) :
                    EX_rTaken ? (pc_cnt == CMAX ? pc_cnt : pc_cnt + ONE) :
                                (pc_cnt == '0 ? pc_cnt : pc_cnt - ONE);

   assign hk         = kind[if_set][if_way];
   assign IF_pTaken  = |if_hit && (hk != 2'd0 || pht[if_idx][CNT_BITS-1]);
   assign IF_pTarget = !(|if_hit) ? 32'h0 : (hk == 2'd3 && ras_ok) ? ras_top : target[if_set][if_way];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid  <= '{default: '0};
         tag    <= '{default: '0};
         target <= '{default: '0};
         kind   <= '{default: '0};
         lru    <= '0;
         pht    <= '{default: WT};
         ghr    <= '0;
      end else if (flush) begin
         valid  <= '{default: '0};
         tag    <= '{default: '0};
         target <= '{default: '0};
         kind   <= '{default: '0};
         lru    <= '0;
         pht    <= '{default: WT};
         ghr    <= '0;
      end else if (upd) begin
         valid[ex_set][ex_way]  <= 1'b1;
         tag[ex_set][ex_way]    <= ex_tag;
         target[ex_set][ex_way] <= EX_bTarget;
         kind[ex_set][ex_way]   <= ex_kind;
         lru[ex_set]            <= !ex_way;
         if (is_cond) begin
            ghr         <= {ghr[HIST_LEN-2:0], EX_rTaken};
            pht[ex_idx] <= cnt_nxt;
         end
      end
   end

`ifdef BP_RAS_EN
   localparam int RB = $clog2(RAS_DEPTH);
   localparam logic [RB:0] RAS_FULL = (RB+1)'(RAS_DEPTH);
   logic [31:0] ras [RAS_DEPTH];
   logic [RB-1:0] ras_tp;
   logic [RB:0]   ras_cnt;

   // Circular stack: overflow overwrites the oldest entry, pop on empty is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ras     <= '{default: '0};
         ras_tp  <= '0;
         ras_cnt <= '0;
      end else if (flush) begin
         ras     <= '{default: '0};
         ras_tp  <= '0;
         ras_cnt <= '0;
      end else if (upd && EX_bType == 3'b011) begin
         ras[ras_tp + RB'(1)] <= EX_linkAddr;
         ras_tp               <= ras_tp + RB'(1);
         ras_cnt              <= ras_cnt == RAS_FULL ? ras_cnt : ras_cnt + (RB+1)'(1);
      end else if (upd && EX_bType == 3'b100 && ras_cnt != '0) begin
         ras_tp  <= ras_tp - RB'(1);
         ras_cnt <= ras_cnt - (RB+1)'(1);
      end
   end

   assign ras_ok    = ras_cnt != '0;
   assign ras_top   = ras[ras_tp];
   assign unused_ok = ^{IF_PC[1:0], EX_PC[1:0]};
`else
   assign ras_ok    = 1'b0;
   assign ras_top   = 32'h0;
   assign unused_ok = ^{EX_linkAddr, IF_PC[1:0], EX_PC[1:0], RAS_DEPTH != 0};
`endif
endmodule

// File: tb/tb_branch_predictor_gs2.sv
// tb_branch_predictor_gs2: directed checks of BTB fill/LRU, gshare training, gating, flush, RAS and async reset.
module tb_branch_predictor_gs2;
   logic        clk = 0, rst = 0, IF_DONE = 1, MEM_DONE = 1, flush = 0, EX_rTaken = 0, IF_pTaken;
   logic [31:0] IF_PC = 0, IF_pTarget, EX_PC = 0, EX_bTarget = 0, EX_linkAddr = 0;
   logic [2:0]  EX_bType = 0;
   logic [31:0] ras_exp [6];
   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   branch_predictor_gs2 dut (
      .clk(clk), .rst(rst), .IF_DONE(IF_DONE), .MEM_DONE(MEM_DONE), .flush(flush),
      .IF_PC(IF_PC), .IF_pTaken(IF_pTaken), .IF_pTarget(IF_pTarget),
      .EX_bType(EX_bType), .EX_rTaken(EX_rTaken), .EX_PC(EX_PC),
      .EX_bTarget(EX_bTarget), .EX_linkAddr(EX_linkAddr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic look(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input string tag);
      IF_PC = pc;
      #1;
      check({tag, "_tk"}, 32'(IF_pTaken), 32'(tk));
      check({tag, "_tgt"}, IF_pTarget, tgt);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [2:0] ty, input logic tk, input logic [31:0] tgt);
      EX_PC = pc; EX_bType = ty; EX_rTaken = tk; EX_bTarget = tgt; EX_linkAddr = pc + 32'd4;
      @(posedge clk);
      #1 EX_bType = 3'b000;
   endtask

   task automatic reset_dut;
      rst = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
   endtask

   initial begin
`ifdef BP_RAS_EN
      ras_exp = '{32'h54, 32'h44, 32'h34, 32'h24, 32'hABC, 32'hABC};
`else
      ras_exp = '{default: 32'hABC};
`endif
      repeat (2) @(posedge clk);
      #1 look(32'h100, 0, 0, "in_reset");
      rst = 1;
      look(32'h100, 0, 0, "cold");

      // first conditional fill: not visible to IF until the next edge
      EX_PC = 32'h100; EX_bType = 3'b010; EX_rTaken = 1; EX_bTarget = 32'h80;
      look(32'h100, 0, 0, "same_cycle");
      @(posedge clk);
      #1 EX_bType = 3'b000;
      look(32'h100, 1, 32'h80, "cond_fill");
      for (int i = 1; i <= 9; i++) begin
         upd(32'h100, 3'b010, 0, 32'h80);
         if (i == 1 || i == 6) look(32'h100, 1, 32'h80, $sformatf("cond_nt%0d", i));
         if (i >= 7) look(32'h100, 0, 32'h80, $sformatf("cond_nt%0d", i));
      end
      upd(32'h100, 3'b010, 1, 32'h80);
      look(32'h100, 0, 32'h80, "cond_inc");

      reset_dut();
      upd(32'h00, 3'b001, 1, 32'h1000);
      upd(32'h20, 3'b001, 1, 32'h2000);
      upd(32'h40, 3'b001, 1, 32'h4000);
      look(32'h20, 1, 32'h2000, "lru_a");
      look(32'h40, 1, 32'h4000, "lru_b");
      look(32'h00, 0, 0, "lru_evict");
      upd(32'h20, 3'b101, 1, 32'h2222);
      upd(32'h60, 3'b001, 1, 32'h6000);
      look(32'h40, 0, 0, "lru_hit_evict");
      look(32'h20, 1, 32'h2222, "lru_refresh");
      look(32'h60, 1, 32'h6000, "lru_new");

      MEM_DONE = 0;
      upd(32'h80, 3'b001, 1, 32'h8000);
      MEM_DONE = 1;
      look(32'h80, 0, 0, "gate_mem");
      IF_DONE = 0;
      upd(32'h88, 3'b001, 1, 32'h8800);
      IF_DONE = 1;
      look(32'h88, 0, 0, "gate_if");

      upd(32'h104, 3'b010, 1, 32'h500);
      flush = 1;
      upd(32'h84, 3'b001, 1, 32'h8400);
      flush = 0;
      look(32'h20, 0, 0, "flush_a");
      look(32'h60, 0, 0, "flush_b");
      look(32'h84, 0, 0, "flush_upd");
      upd(32'h100, 3'b010, 0, 32'h80);
      look(32'h100, 0, 32'h80, "flush_ghr");

      reset_dut();
      upd(32'h20C, 3'b100, 1, 32'hABC);
      for (int i = 1; i <= 5; i++) upd(32'h10 * i, 3'b011, 1, 32'h800);
      for (int k = 0; k < 6; k++) begin
         look(32'h20C, 1, ras_exp[k], $sformatf("ras%0d", k));
         upd(32'h20C, 3'b100, 1, 32'hABC);
      end
      upd(32'h60, 3'b011, 1, 32'h800);
`ifdef BP_RAS_EN
      look(32'h20C, 1, 32'h64, "ras_after_empty");
`else
      look(32'h20C, 1, 32'hABC, "ras_after_empty");
`endif
      upd(32'h20C, 3'b100, 1, 32'hABC);
      look(32'h20C, 1, 32'hABC, "ras_drain");

      rst = 0;
      look(32'h20C, 0, 0, "async_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
